// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, the NOP word and the
// default memory-map constants used by the fetch stage and its IF/ID register.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetchState_t;

    localparam logic [31:0] NOP               = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: flush beats hold, hold beats load; a load always
// marks the entry valid.
module if_id_register
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        hold,
    input  logic [31:0] instrNext,
    input  logic [31:0] pc4Next,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc4
);

    logic        vld_p1;
    logic [31:0] instr_p1;
    logic [31:0] pc4_p1;

    // IF -> ID boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            instr_p1 <= NOP;
            pc4_p1   <= '0;
        end else if (flush) begin
            vld_p1   <= 1'b0;
            instr_p1 <= NOP;
        end else if (!hold) begin
            vld_p1   <= 1'b1;
            instr_p1 <= instrNext;
            pc4_p1   <= pc4Next;
        end
    end

    assign valid = vld_p1;
    assign instr = instr_p1;
    assign pc4   = pc4_p1;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/FAULT control and a
// saturating delivered-instruction counter feeding a single IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter logic [31:0] TEXT_BASE    = DEFAULT_TEXT_BASE,
    parameter int          MEMORY_DEPTH = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instr_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [32:0] MEM_BYTES = 33'(MEMORY_DEPTH) << 2;

    fetchState_t state, nextState;
    logic [31:0] pcReg, nextPc, countReg;
    logic [32:0] seqSum;
    logic        hold, flush, countInc;

    function automatic logic isIllegal(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - TEXT_BASE;
        return (addr[1:0] != 2'b00) || (addr < TEXT_BASE) || ({1'b0, offset} >= MEM_BYTES);
    endfunction

    // Carry out of PC+4 marks a wrapped address, which is never fetchable.
    assign seqSum = {1'b0, pcReg} + 33'd4;

    always_comb begin
        nextState = state;
        nextPc    = pcReg;
        hold      = 1'b1;
        flush     = 1'b0;
        countInc  = 1'b0;
        unique case (state)
            BOOT: begin
                nextState = isIllegal(pcReg) ? FAULT : RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    nextPc = redirect_target;
                    flush  = 1'b1;
                    if (isIllegal(redirect_target)) nextState = FAULT;
                end else if (!stall) begin
                    nextPc   = seqSum[31:0];
                    hold     = 1'b0;
                    countInc = 1'b1;
                    if (seqSum[32] || isIllegal(seqSum[31:0])) nextState = FAULT;
                end
            end
            FAULT: begin
                flush = 1'b1;
            end
            default: begin
                nextState = FAULT;
                flush     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
            pcReg <= RESET_PC;
        end else begin
            state <= nextState;
            pcReg <= nextPc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            countReg <= '0;
        end else if (countInc && (countReg != 32'hFFFF_FFFF)) begin
            countReg <= countReg + 32'd1;
        end
    end

    if_id_register ifIdReg (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .hold      (hold),
        .instrNext (instr_rdata),
        .pc4Next   (seqSum[31:0]),
        .valid     (if_id_valid),
        .instr     (if_id_instr),
        .pc4       (if_id_pc4)
    );

    assign imem_addr   = pcReg - TEXT_BASE;
    assign pc          = pcReg;
    assign fault       = (state == FAULT);
    assign fetch_count = countReg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, sequential fetch, stall, redirect,
// misaligned and end-of-memory faults, and asynchronous reset.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_rdata;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] rom [0:511];
    int compared   = 0;
    int mismatched = 0;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_rdata     (instr_rdata),
        .imem_addr       (imem_addr),
        .pc              (pc),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    always_comb instr_rdata = rom[imem_addr[10:2]];

    function automatic logic [31:0] romWord(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        #1;
        compared++;
        if ({pc, if_id_valid, if_id_instr, if_id_pc4, fault, fetch_count} !==
            {32'h0040_0000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            mismatched++;
            $display("FAIL reset_state: pc=%h v=%b i=%h p4=%h f=%b n=%0d, want pc=00400000 rest zero",
                     pc, if_id_valid, if_id_instr, if_id_pc4, fault, fetch_count);
        end
        compared++;
        if (imem_addr !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_imem_addr: got %h want 00000000", imem_addr);
        end
    endtask

    task automatic test_sequential();
        step();
        compared++;
        if (if_id_valid !== 1'b0 || pc !== 32'h0040_0000) begin
            mismatched++;
            $display("FAIL boot_cycle: v=%b pc=%h want v=0 pc=00400000", if_id_valid, pc);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            compared++;
            if (if_id_valid !== 1'b1 || if_id_instr !== romWord(k) ||
                if_id_pc4 !== 32'h0040_0004 + 32'(4 * k) || pc !== 32'h0040_0004 + 32'(4 * k)) begin
                mismatched++;
                $display("FAIL seq_word%0d: v=%b i=%h p4=%h pc=%h want v=1 i=%h p4=%h",
                         k, if_id_valid, if_id_instr, if_id_pc4, pc, romWord(k), 32'h0040_0004 + 32'(4 * k));
            end
        end
        compared++;
        if (fetch_count !== 32'd4) begin
            mismatched++;
            $display("FAIL seq_count: got %0d want 4", fetch_count);
        end
    endtask

    task automatic test_stall();
        doReset();
        for (int k = 0; k < 3; k++) step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            compared++;
            if (if_id_instr !== romWord(1) || pc !== 32'h0040_0008 ||
                if_id_valid !== 1'b1 || fetch_count !== 32'd2) begin
                mismatched++;
                $display("FAIL stall_hold%0d: i=%h pc=%h v=%b n=%0d want i=%h pc=00400008 v=1 n=2",
                         k, if_id_instr, pc, if_id_valid, fetch_count, romWord(1));
            end
        end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h0040_0040;
        step();
        compared++;
        if (pc !== 32'h0040_0040 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            mismatched++;
            $display("FAIL redirect_flush: pc=%h v=%b i=%h want pc=00400040 v=0 i=0", pc, if_id_valid, if_id_instr);
        end
        compared++;
        if (imem_addr !== 32'h0000_0040) begin
            mismatched++;
            $display("FAIL redirect_imem_addr: got %h want 00000040", imem_addr);
        end
        stall = 1'b0;
        redirect_valid = 1'b0;
        step();
        compared++;
        if (if_id_valid !== 1'b1 || if_id_instr !== romWord(16) || if_id_pc4 !== 32'h0040_0044 ||
            fetch_count !== 32'd3) begin
            mismatched++;
            $display("FAIL redirect_word16: v=%b i=%h p4=%h n=%0d want v=1 i=%h p4=00400044 n=3",
                     if_id_valid, if_id_instr, if_id_pc4, fetch_count, romWord(16));
        end
    endtask

    task automatic test_misaligned_fault();
        redirect_valid = 1'b1;
        redirect_target = 32'h0040_0042;
        step();
        compared++;
        if (fault !== 1'b1 || if_id_valid !== 1'b0 || pc !== 32'h0040_0042 || if_id_instr !== 32'h0) begin
            mismatched++;
            $display("FAIL misalign_fault: f=%b v=%b pc=%h i=%h want f=1 v=0 pc=00400042 i=0",
                     fault, if_id_valid, pc, if_id_instr);
        end
        stall = 1'b1;
        redirect_target = 32'h0040_0100;
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        step();
        compared++;
        if (fault !== 1'b1 || if_id_valid !== 1'b0 || pc !== 32'h0040_0042 || fetch_count !== 32'd3) begin
            mismatched++;
            $display("FAIL fault_frozen: f=%b v=%b pc=%h n=%0d want f=1 v=0 pc=00400042 n=3",
                     fault, if_id_valid, pc, fetch_count);
        end
    endtask

    task automatic test_async_reset_fault();
        #3;
        reset = 1'b0;
        #1;
        compared++;
        if ({pc, if_id_valid, if_id_instr, if_id_pc4, fault, fetch_count} !==
            {32'h0040_0000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            mismatched++;
            $display("FAIL async_reset_fault: pc=%h v=%b i=%h p4=%h f=%b n=%0d want pc=00400000 rest zero",
                     pc, if_id_valid, if_id_instr, if_id_pc4, fault, fetch_count);
        end
    endtask

    task automatic test_async_reset_stall();
        doReset();
        for (int k = 0; k < 3; k++) step();
        stall = 1'b1;
        step();
        #3;
        reset = 1'b0;
        #1;
        compared++;
        if ({pc, if_id_valid, if_id_instr, if_id_pc4, fault, fetch_count} !==
            {32'h0040_0000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            mismatched++;
            $display("FAIL async_reset_stall: pc=%h v=%b i=%h p4=%h f=%b n=%0d want pc=00400000 rest zero",
                     pc, if_id_valid, if_id_instr, if_id_pc4, fault, fetch_count);
        end
    endtask

    task automatic test_end_of_memory();
        doReset();
        step();
        redirect_valid = 1'b1;
        redirect_target = 32'h0040_07FC;
        step();
        redirect_valid = 1'b0;
        compared++;
        if (pc !== 32'h0040_07FC || fault !== 1'b0) begin
            mismatched++;
            $display("FAIL eom_setup: pc=%h f=%b want pc=004007fc f=0", pc, fault);
        end
        step();
        compared++;
        if (if_id_valid !== 1'b1 || if_id_instr !== romWord(511) || if_id_pc4 !== 32'h0040_0800 ||
            fetch_count !== 32'd1) begin
            mismatched++;
            $display("FAIL eom_last_word: v=%b i=%h p4=%h n=%0d want v=1 i=%h p4=00400800 n=1",
                     if_id_valid, if_id_instr, if_id_pc4, fetch_count, romWord(511));
        end
        compared++;
        if (fault !== 1'b1 || pc !== 32'h0040_0800) begin
            mismatched++;
            $display("FAIL eom_fault: f=%b pc=%h want f=1 pc=00400800", fault, pc);
        end
        step();
        compared++;
        if (fault !== 1'b1 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
            pc !== 32'h0040_0800 || fetch_count !== 32'd1) begin
            mismatched++;
            $display("FAIL eom_after: f=%b v=%b i=%h pc=%h n=%0d want f=1 v=0 i=0 pc=00400800 n=1",
                     fault, if_id_valid, if_id_instr, pc, fetch_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = romWord(i);
        reset = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_over_stall();
        test_misaligned_fault();
        test_async_reset_fault();
        test_async_reset_stall();
        test_end_of_memory();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
